// File: rtl/fft_pair_feeder_pkg.sv
// Shared types and defaults for the FFT front-end feeder: the complex sample
// word, frame/flush defaults and the emitter state encoding.
package fft_pair_feeder_pkg;

    typedef struct packed {
        logic signed [31:0] r;
        logic signed [31:0] i;
    } complex_product_t;

    localparam int unsigned FFT_N            = 8;
    localparam int unsigned FFT_FLUSH_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        FLUSH = 2'd2
    } fft_feed_state_e;

endpackage

// File: rtl/fft_pingpong_buf.sv
// Two N-word sample banks with per-bank full flags; one write port and a
// dual read port returning x[k] and x[k+N/2] from the selected bank.
module fft_pingpong_buf
    import fft_pair_feeder_pkg::*;
#(
    parameter int unsigned N = FFT_N
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic                   wr_bank,
    input  logic [$clog2(N)-1:0]   wr_idx,
    input  complex_product_t       wr_data,
    input  logic                   wr_done,
    input  logic                   rd_bank,
    input  logic [$clog2(N)-2:0]   rd_k,
    input  logic                   clr,
    input  logic                   clr_bank,
    output complex_product_t       rd_data_0,
    output complex_product_t       rd_data_1,
    output logic [1:0]             full
);

    complex_product_t mem [2][N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    // Writer and emitter never target the same bank in one cycle, so set
    // and clear cannot collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= '0;
        end else begin
            if (wr_done) begin
                full[wr_bank] <= 1'b1;
            end
            if (clr) begin
                full[clr_bank] <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data_0 = mem[rd_bank][{1'b0, rd_k}];
        rd_data_1 = mem[rd_bank][{1'b1, rd_k}];
    end

endmodule

// File: rtl/fft_pair_feeder.sv
// Serial-to-butterfly-pair feeder for fft_8_rad2: buffers N-sample frames
// in ping-pong banks, emits N/2 contiguous pairs, then flushes with zeros.
module fft_pair_feeder
    import fft_pair_feeder_pkg::*;
#(
    parameter int unsigned N            = FFT_N,
    parameter int unsigned FLUSH_CYCLES = FFT_FLUSH_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  complex_product_t in_data,
    input  logic             out_hold,
    output logic             enable,
    output logic             sof,
    output complex_product_t data_0,
    output complex_product_t data_1
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned KW = IW - 1;
    localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [KW-1:0] LAST_K   = KW'(N / 2 - 1);

    fft_feed_state_e  state;
    logic [IW-1:0]    wr_cnt;
    logic             w_bank;
    logic             r_bank;
    logic [KW-1:0]    k;
    logic [FW-1:0]    flush_cnt;
    logic [1:0]       full;
    logic             accept;
    logic             wr_done;
    logic             last_pair;
    logic             rd_bank_sel;
    logic [KW-1:0]    rd_k_sel;
    logic             start_ok;
    complex_product_t rd_data_0;
    complex_product_t rd_data_1;

    always_comb begin
        in_ready = !reset && !full[w_bank];
        accept   = in_valid && in_ready;
        wr_done  = accept && (wr_cnt == LAST_IDX);
    end

    // The read address always points at the pair to be registered on the
    // next edge; on the last pair it already looks into the other bank so
    // back-to-back frames need no gap cycle.
    always_comb begin
        last_pair   = (state == EMIT) && (k == LAST_K);
        rd_bank_sel = last_pair ? ~r_bank : r_bank;
        rd_k_sel    = ((state == EMIT) && !last_pair) ? k + 1'b1 : '0;
        start_ok    = full[rd_bank_sel] && !out_hold;
    end

    fft_pingpong_buf #(
        .N (N)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .we        (accept),
        .wr_bank   (w_bank),
        .wr_idx    (wr_cnt),
        .wr_data   (in_data),
        .wr_done   (wr_done),
        .rd_bank   (rd_bank_sel),
        .rd_k      (rd_k_sel),
        .clr       (last_pair),
        .clr_bank  (r_bank),
        .rd_data_0 (rd_data_0),
        .rd_data_1 (rd_data_1),
        .full      (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt <= '0;
            w_bank <= 1'b0;
        end else if (accept) begin
            wr_cnt <= wr_done ? '0 : wr_cnt + 1'b1;
            if (wr_done) begin
                w_bank <= ~w_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            r_bank    <= 1'b0;
            k         <= '0;
            flush_cnt <= '0;
            enable    <= 1'b0;
            sof       <= 1'b0;
            data_0    <= '0;
            data_1    <= '0;
        end else begin
            enable <= 1'b1;
            sof    <= 1'b0;
            data_0 <= '0;
            data_1 <= '0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state  <= EMIT;
                        k      <= '0;
                        sof    <= 1'b1;
                        data_0 <= rd_data_0;
                        data_1 <= rd_data_1;
                    end else begin
                        enable <= 1'b0;
                    end
                end
                EMIT: begin
                    if (!last_pair) begin
                        k      <= k + 1'b1;
                        data_0 <= rd_data_0;
                        data_1 <= rd_data_1;
                    end else begin
                        r_bank <= ~r_bank;
                        if (start_ok) begin
                            k      <= '0;
                            sof    <= 1'b1;
                            data_0 <= rd_data_0;
                            data_1 <= rd_data_1;
                        end else begin
                            state     <= FLUSH;
                            flush_cnt <= FW'(FLUSH_CYCLES - 1);
                        end
                    end
                end
                FLUSH: begin
                    if (start_ok) begin
                        state  <= EMIT;
                        k      <= '0;
                        sof    <= 1'b1;
                        data_0 <= rd_data_0;
                        data_1 <= rd_data_1;
                    end else if (flush_cnt == '0) begin
                        state  <= IDLE;
                        enable <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_pair_feeder.sv
// Scoreboard bench for fft_pair_feeder: expected pairs are queued as frames
// are accepted and popped when the feeder emits non-zero data.
module tb_fft_pair_feeder;
    import fft_pair_feeder_pkg::*;

    localparam int TN = 8;

    typedef struct {
        complex_product_t d0;
        complex_product_t d1;
        logic             sof;
    } pair_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    complex_product_t in_data = '0;
    logic             out_hold = 1'b0;
    logic             enable;
    logic             sof;
    complex_product_t data_0;
    complex_product_t data_1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pair_t            exp_q[$];
    complex_product_t frame_buf[$];
    int               pair_cyc[$];

    fft_pair_feeder #(
        .N            (TN),
        .FLUSH_CYCLES (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_hold (out_hold),
        .enable   (enable),
        .sof      (sof),
        .data_0   (data_0),
        .data_1   (data_1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model_push(input complex_product_t s);
        frame_buf.push_back(s);
        if (frame_buf.size() == TN) begin
            for (int k = 0; k < TN / 2; k++) begin
                pair_t p;
                p.d0  = frame_buf[k];
                p.d1  = frame_buf[k + TN / 2];
                p.sof = (k == 0);
                exp_q.push_back(p);
            end
            frame_buf.delete();
        end
    endfunction

    // Any cycle with enable and non-zero data is a pair and must match the queue head.
    always @(negedge clk) begin
        if (reset === 1'b0 && enable === 1'b1 && (data_0 != '0 || data_1 != '0)) begin
            pair_t e;
            pair_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pair: got d0=(%0d,%0d) d1=(%0d,%0d), want no pair",
                         data_0.r, data_0.i, data_1.r, data_1.i);
            end else begin
                e = exp_q.pop_front();
                if (data_0 !== e.d0 || data_1 !== e.d1 || sof !== e.sof) begin
                    errors++;
                    $display("FAIL pair_data: got d0=(%0d,%0d) d1=(%0d,%0d) sof=%0b, want d0=(%0d,%0d) d1=(%0d,%0d) sof=%0b",
                             data_0.r, data_0.i, data_1.r, data_1.i, sof,
                             e.d0.r, e.d0.i, e.d1.r, e.d1.i, e.sof);
                end
            end
        end
    end

    task automatic drive_frame(input int n, input int base_r, input int step_r, input int step_i,
                               input bit toggle, output int last_acc);
        int sent = 0;
        int budget = 0;
        bit phase = 1'b1;
        bit acc;
        int c;
        last_acc = -1;
        while (sent < n && budget < 400) begin
            @(negedge clk);
            c = cyc;
            in_data.r = base_r + step_r * sent;
            in_data.i = step_i * sent;
            in_valid  = toggle ? phase : 1'b1;
            phase     = ~phase;
            acc       = in_valid && in_ready;
            @(posedge clk);
            if (acc) begin
                model_push(in_data);
                sent++;
                last_acc = c + 1;
            end
            budget++;
        end
        #1 in_valid = 1'b0;
        checks++;
        if (sent != n) begin
            errors++;
            $display("FAIL drive_timeout: got %0d accepted, want %0d", sent, n);
        end
    endtask

    task automatic observe(input int budget, output int pairs, output int mid, output int trail,
                           output int sof_bad, output bit timeout);
        bit started = 1'b0;
        int zeros = 0;
        pairs = 0; trail = 0; sof_bad = 0; timeout = 1'b1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (enable === 1'b1) begin
                started = 1'b1;
                if (data_0 != '0 || data_1 != '0) begin
                    pairs++;
                    trail = 0;
                end else begin
                    zeros++;
                    trail++;
                    if (sof !== 1'b0) sof_bad++;
                end
            end else if (started) begin
                timeout = 1'b0;
                break;
            end
        end
        mid = zeros - trail;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        frame_buf.delete();
        pair_cyc.delete();
    endtask

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (enable !== 1'b0 || sof !== 1'b0 || data_0 !== '0 || data_1 !== '0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: got en=%b sof=%b d0r=%0d d1r=%0d rdy=%b, want all 0",
                         enable, sof, data_0.r, data_1.r, in_ready);
            end
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b en=%b, want rdy=1 en=0", in_ready, enable);
        end
    endtask

    task automatic test_single_frame(input bit toggle, input string nm);
        int last, pairs, mid, trail, sofb;
        bit to;
        pair_cyc.delete();
        fork
            drive_frame(TN, 256, 256, 0, toggle, last);
            observe(300, pairs, mid, trail, sofb, to);
        join
        checks++;
        if (to || pairs != 4 || mid != 0 || sofb != 0) begin
            errors++;
            $display("FAIL %s_shape: got to=%0b pairs=%0d gaps=%0d sofbad=%0d, want 0 4 0 0", nm, to, pairs, mid, sofb);
        end
        checks++;
        if (trail != 16) begin
            errors++;
            $display("FAIL %s_flush: got %0d zero cycles, want 16", nm, trail);
        end
        checks++;
        if (pair_cyc.size() != 4 || pair_cyc[0] != last + 1 || pair_cyc[3] != pair_cyc[0] + 3) begin
            errors++;
            $display("FAIL %s_timing: got n=%0d first=%0d, want 4 pairs from %0d", nm, pair_cyc.size(),
                     pair_cyc.size() > 0 ? pair_cyc[0] : -1, last + 1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: got %0d pending pairs, want 0", nm, exp_q.size());
        end
    endtask

    task automatic test_hold();
        int last, pairs, mid, trail, sofb, hcyc, rise;
        bit to;
        pair_cyc.delete();
        rise = -1;
        hcyc = 0;
        out_hold = 1'b1;
        fork
            begin
                drive_frame(2 * TN, 1, 1, 0, 1'b0, last);
                for (int n = 0; n < 4; n++) begin
                    @(negedge clk);
                    in_valid  = 1'b1;
                    in_data.r = 17;
                    in_data.i = 0;
                    checks++;
                    if (in_ready !== 1'b0 || enable !== 1'b0) begin
                        errors++;
                        $display("FAIL hold_stall: got rdy=%b en=%b, want 0 0", in_ready, enable);
                    end
                end
                out_hold = 1'b0;
                hcyc = cyc;
                for (int n = 0; n < 30; n++) begin
                    @(negedge clk);
                    if (in_ready === 1'b1) begin
                        rise = cyc;
                        @(posedge clk);
                        model_push(in_data);
                        #1 in_valid = 1'b0;
                        break;
                    end
                end
                in_valid = 1'b0;
            end
            observe(300, pairs, mid, trail, sofb, to);
        join
        checks++;
        if (to || pairs != 8 || mid != 0 || trail != 16 || sofb != 0) begin
            errors++;
            $display("FAIL hold_shape: got to=%0b pairs=%0d gaps=%0d flush=%0d sofbad=%0d, want 0 8 0 16 0",
                     to, pairs, mid, trail, sofb);
        end
        checks++;
        if (pair_cyc.size() != 8 || pair_cyc[0] != hcyc + 1 || pair_cyc[7] != pair_cyc[0] + 7) begin
            errors++;
            $display("FAIL hold_timing: got n=%0d, want 8 contiguous pairs from %0d", pair_cyc.size(), hcyc + 1);
        end
        checks++;
        if (pair_cyc.size() < 4 || rise != pair_cyc[3] + 1) begin
            errors++;
            $display("FAIL hold_ready_rise: got cycle %0d, want one after 4th pair", rise);
        end
        checks++;
        if (frame_buf.size() != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL hold_17th: got partial=%0d pending=%0d, want 1 0", frame_buf.size(), exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int last, pairs, mid, trail, sofb;
        bit to;
        pair_cyc.delete();
        fork
            drive_frame(2 * TN, 100, 3, -7, 1'b0, last);
            observe(300, pairs, mid, trail, sofb, to);
        join
        checks++;
        if (to || pairs != 8 || trail != 16 || sofb != 0) begin
            errors++;
            $display("FAIL b2b_shape: got to=%0b pairs=%0d flush=%0d sofbad=%0d, want 0 8 16 0", to, pairs, trail, sofb);
        end
        checks++;
        if (mid != 4) begin
            errors++;
            $display("FAIL b2b_abort: got %0d flush cycles between frames, want 4", mid);
        end
        checks++;
        if (pair_cyc.size() != 8 || pair_cyc[4] != last + 1 || pair_cyc[4] != pair_cyc[3] + 5
            || pair_cyc[3] != pair_cyc[0] + 3) begin
            errors++;
            $display("FAIL b2b_timing: got n=%0d, want frame 2 at %0d", pair_cyc.size(), last + 1);
        end
    endtask

    task automatic test_reset_mid();
        int last, pairs, mid, trail, sofb;
        bit to;
        pair_cyc.delete();
        drive_frame(TN, 50, 50, 5, 1'b0, last);
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            if (pair_cyc.size() >= 2) break;
        end
        checks++;
        if (pair_cyc.size() < 2) begin
            errors++;
            $display("FAIL midreset_pairs: got %0d pairs, want 2", pair_cyc.size());
        end
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (enable !== 1'b0 || sof !== 1'b0 || data_0 !== '0 || data_1 !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got en=%b sof=%b d0r=%0d d1r=%0d, want all 0",
                     enable, sof, data_0.r, data_1.r);
        end
        exp_q.delete();
        frame_buf.delete();
        pair_cyc.delete();
        fork
            drive_frame(TN, 3000, 7, -2, 1'b0, last);
            observe(300, pairs, mid, trail, sofb, to);
        join
        checks++;
        if (to || pairs != 4 || mid != 0 || trail != 16 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_fresh: got to=%0b pairs=%0d gaps=%0d flush=%0d pending=%0d, want 0 4 0 16 0",
                     to, pairs, mid, trail, exp_q.size());
        end
        checks++;
        if (pair_cyc.size() != 4 || pair_cyc[0] != last + 1) begin
            errors++;
            $display("FAIL midreset_timing: got n=%0d, want 4 pairs from %0d", pair_cyc.size(), last + 1);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame(1'b0, "frame");
        test_single_frame(1'b1, "toggle");
        test_hold();
        do_reset();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, want finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/fft_pair_feeder.md
Name: fft_pair_feeder

Overview:
- Front-end source for fft_8_rad2. Accepts a serial stream of complex samples through a valid/ready handshake and buffers each N-sample frame in a ping-pong bank pair.
- Drives the FFT input port with one butterfly pair per cycle: data_0 = x[k] and data_1 = x[k+N/2], for k = 0..N/2-1, on N/2 consecutive cycles.
- Keeps enable asserted with zero data for a programmable flush window so the FFT pipeline drains to its outputs.

Parameters:
- N, 8, FFT size; power of two, at least 4.
- FLUSH_CYCLES, 16, cycles of enable=1 with zero data after a frame when no next frame is ready.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset; one clock domain (clk), sampled on rising edge
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  feeder can accept in_data this cycle
- in_data  input  complex_product_t  serial time-domain sample; frame order x[0]..x[N-1]
- out_hold  input  1  downstream gate; blocks the start of a new frame only
- enable  output  1  drives fft_8_rad2 enable
- sof  output  1  one-cycle pulse aligned with the k=0 pair of each frame
- data_0  output  complex_product_t  x[k]
- data_1  output  complex_product_t  x[k+N/2]

Behaviour:
- Reset values: enable=0, sof=0, data_0=0, data_1=0 (r and i); both banks empty; write bank=0, read bank=0, sample counter=0, emitter=IDLE. in_ready=0 while reset is high and 1 in the first cycle after release.
- Transfer: a sample is accepted on a rising edge when in_valid && in_ready.
- Write side:
  - Accepted sample n is stored at bank[w][n], and the counter increments.
  - On accepting sample N-1: full[w] is set, the counter wraps to 0, and w toggles.
  - in_ready = !full[w] (combinational from registers).
- Emitter FSM (states IDLE, EMIT, FLUSH); all outputs are registered.
  - IDLE: enable=0, data=0. Go to EMIT when full[r] && !out_hold.
  - EMIT: k counts 0..N/2-1. Each cycle drives enable=1, data_0=bank[r][k], data_1=bank[r][k+N/2], and sof=(k==0).
    - After the k=N/2-1 pair: clear full[r] and toggle r.
    - If the other bank is full and out_hold=0, go to EMIT with k=0 (no gap). Otherwise go to FLUSH.
  - FLUSH: enable=1, data=0, sof=0, counting FLUSH_CYCLES.
    - A full bank with out_hold=0 aborts the flush; EMIT starts on the next cycle.
    - When the count expires, go to IDLE.
- out_hold is sampled only at frame boundaries (IDLE, FLUSH, or the last EMIT cycle). A frame that has started always completes its N/2 contiguous pairs.
- Latency: sample N-1 is accepted at edge t; the k=0 pair (enable=1, sof=1) is on the outputs after edge t+1, when out_hold=0 and the emitter is not busy.
- Simultaneous events:
  - The emitter clearing full[r] and the writer needing the same bank: in_ready rises the cycle after the clear. No same-cycle bypass.
  - A write to bank w while bank r is being read is always legal (w≠r whenever r is being emitted and w is filling).
- Continuous input never stalls: a fill takes N cycles and an emit takes N/2. in_ready drops only when both banks are full, which requires out_hold.
- Reset mid-operation: all state returns to reset values on the next edge. Partial frames and unsent pairs are discarded, with no residual pairs after release.
- Data is passed through bit-exact. There is no arithmetic, scaling or saturation.

Decomposition:
- headers.svh (shared): complex_product_t (existing). Add FFT_N and FFT_FLUSH_CYCLES localparam defaults and an fft_feed_state_e enum (IDLE, EMIT, FLUSH).
- One natural sub-module: fft_pingpong_buf.
  - Two banks of N complex_product_t words.
  - Write port: index, data, we, and a bank-done strobe.
  - Dual read port: k and k+N/2 from the read bank.
  - full[1:0] flags with set/clear.
  - The top level keeps the handshake, the counters and the FSM.

Test Plan:
1. Reset held for 3 cycles, then released → enable=0, sof=0, data=0 during reset; in_ready=1 in the first cycle after release.
2. One frame, r = 256,512,...,2048, i=0, in_valid continuous:
   - Pairs (256,1280), (512,1536), (768,1792), (1024,2048) on 4 consecutive cycles, starting one edge after sample 8 is accepted.
   - sof only on the first pair.
   - Then 16 cycles of enable=1 with zero data, then enable=0.
3. Same frame with in_valid toggling every other cycle → identical 4 contiguous pairs; the first pair appears one edge after the 8th acceptance.
4. out_hold=1, push 17 samples (r = 1..17, i=0):
   - in_ready=0 after the 16th is accepted; the 17th stalls; enable stays 0.
   - Release out_hold → 8 contiguous pairs (two frames, sof on the 1st and 5th).
   - in_ready=1 in the cycle after the 4th pair; the 17th sample is then accepted.
5. Two frames streamed back-to-back with continuous in_valid:
   - Frame 1: 4 pairs, then flush.
   - The flush is aborted when frame 2 fills (4 cycles after the last pair of frame 1, under continuous input).
   - Frame 2: 4 pairs with sof.
6. Reset for 1 cycle after the 2nd pair → enable=0 and data=0 the next cycle. A fresh frame fed after reset yields only its own 4 correct pairs, with no stale data.
